stream_buffer_sender: RTL

//  Parametrised sample streamer: replays a block of quantised filter samples from a

---
 rtl/stream_buffer_sender_if.sv | 31 +++
 rtl/stream_buffer_sender.sv | 125 ++++++++++++
 2 files changed

// File: rtl/stream_buffer_sender_if.sv
// Bundle of the streamer's control, RAM read port and output stream signals.
// master = the streamer itself; slave = its environment (controller, RAM, buffer).
`timescale 1ns/1ps
interface stream_buffer_sender_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] cfg_last;
  logic              cfg_loop;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, cfg_last, cfg_loop, rd_data, m_ready,
    output rd_en, rd_addr, m_data, m_valid, m_last, busy, done
  );

  modport slave (
    output start, abort, cfg_last, cfg_loop, rd_data, m_ready,
    input  rd_en, rd_addr, m_data, m_valid, m_last, busy, done
  );
endinterface

// File: rtl/stream_buffer_sender.sv
// Replays samples 0..cfg_last from a synchronous RAM onto a valid/ready stream,
// single pass or looped, through a 2-entry skid buffer at full throughput.
`timescale 1ns/1ps
module stream_buffer_sender #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  stream_buffer_sender_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] last_q;
  logic              loop_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_vld_q, rd_vld_last_q;
  logic [DATA_W-1:0] out_data_q, sp_data_q;
  logic              out_vld_q, out_last_q, sp_vld_q, sp_last_q;
  logic              done_q;
  logic              xfer, rd_fire, addr_at_last, start_ok, final_read;
  logic [1:0]        fill;

  assign xfer         = out_vld_q & bus.m_ready;
  assign addr_at_last = (addr_q == last_q);
  assign start_ok     = (state_q == IDLE) & bus.start & ~bus.abort;
  assign final_read   = rd_fire & addr_at_last & ~loop_q;

  // Entries that will be held once the read in flight lands; a new read is
  // only safe if one slot is still guaranteed free when its data arrives.
  assign fill    = {1'b0, out_vld_q} + {1'b0, sp_vld_q} + {1'b0, rd_vld_q} - {1'b0, xfer};
  assign rd_fire = ~rst & (state_q == RUN) & ~bus.abort & (fill < 2'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN: begin
        if (bus.abort)       state_d = IDLE;
        else if (final_read) state_d = DRAIN;
      end
      DRAIN:   if (bus.abort || (xfer && out_last_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
    end else if (start_ok) begin
      addr_q <= '0;
      last_q <= bus.cfg_last;
      loop_q <= bus.cfg_loop;
    end else if (rd_fire && !final_read) begin
      addr_q <= addr_at_last ? '0 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q      <= 1'b0;
      rd_vld_last_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      rd_vld_q      <= rd_fire;
      rd_vld_last_q <= addr_at_last;
      done_q        <= (state_q == DRAIN) & xfer & out_last_q & ~bus.abort;
    end
  end

  // Output register refills from the spare first so sample order is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      sp_data_q  <= '0;
      sp_last_q  <= 1'b0;
      sp_vld_q   <= 1'b0;
    end else if (bus.abort) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      sp_vld_q   <= 1'b0;
    end else if (!out_vld_q || xfer) begin
      if (sp_vld_q) begin
        out_data_q <= sp_data_q;
        out_last_q <= sp_last_q;
        out_vld_q  <= 1'b1;
        sp_data_q  <= bus.rd_data;
        sp_last_q  <= rd_vld_last_q;
        sp_vld_q   <= rd_vld_q;
      end else if (rd_vld_q) begin
        out_data_q <= bus.rd_data;
        out_last_q <= rd_vld_last_q;
        out_vld_q  <= 1'b1;
      end else begin
        out_vld_q  <= 1'b0;
        out_last_q <= 1'b0;
      end
    end else if (rd_vld_q) begin
      sp_data_q <= bus.rd_data;
      sp_last_q <= rd_vld_last_q;
      sp_vld_q  <= 1'b1;
    end
  end

  assign bus.rd_en   = rd_fire;
  assign bus.rd_addr = addr_q;
  assign bus.m_data  = out_data_q;
  assign bus.m_valid = out_vld_q;
  assign bus.m_last  = out_last_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule
